// File: rtl/ones_window_counter.sv
`default_nettype none
// ============================================================================
// Module   : ones_window_counter
// Purpose  : Counts set bits in each accepted DATA_W-bit input beat and
//            accumulates them over a programmable window of beats. The
//            window total is presented on a valid/ready output port, with
//            saturate or wrap handling of accumulator overflow.
// Ports    : clk        - rising-edge clock
//            reset      - asynchronous active-low reset
//            clear      - synchronous abort, returns to IDLE
//            mode_sat   - 1 = saturate, 0 = wrap (sampled every beat)
//            win_len    - beats per window, latched on first beat (0 -> 1)
//            in_valid   - input beat present
//            in_ready   - block accepts the beat this cycle
//            in_data    - word whose ones are counted
//            out_valid  - window result available
//            out_ready  - consumer takes the result
//            out_count  - total ones in the window
//            out_ovf    - accumulator overflowed during this window
//            busy       - high while a window is open or a result is held
// Revision : 1.0 - initial release
// ============================================================================
module ones_window_counter #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              mode_sat,
  input  logic [LEN_W-1:0]  win_len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_ovf,
  output logic              busy
);

  localparam int POP_W = $clog2(DATA_W + 1);
  // The add needs at least CNT_W+1 bits; widen further if a single
  // popcount could itself exceed the accumulator range.
  localparam int SUM_W = ((CNT_W + 1) > POP_W) ? (CNT_W + 1) : (POP_W + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_acc;
  logic [LEN_W-1:0] r_beats;
  logic [LEN_W-1:0] r_len;
  logic             r_ovf;

  logic [POP_W-1:0] w_pop;
  logic [CNT_W-1:0] w_base;
  logic [SUM_W-1:0] w_sum;
  logic             w_over;
  logic [CNT_W-1:0] w_acc_next;
  logic             w_ovf_next;
  logic [LEN_W-1:0] w_len_eff;
  logic [LEN_W-1:0] w_len_cur;
  logic [LEN_W-1:0] w_beats_next;
  logic             w_last;
  logic             w_accept;
  logic             w_in_accum;

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < DATA_W; i++) begin
      w_pop = w_pop + POP_W'(in_data[i]);
    end
  end

  assign w_in_accum = (r_state == ST_ACCUM);

  // A beat accepted outside ACCUM (IDLE, or HOLD being drained) opens a
  // fresh window, so the running totals restart from zero.
  assign w_base       = w_in_accum ? r_acc : '0;
  assign w_sum        = SUM_W'(w_base) + SUM_W'(w_pop);
  assign w_over       = (w_sum > SUM_W'({CNT_W{1'b1}}));
  assign w_acc_next   = (w_over && mode_sat) ? {CNT_W{1'b1}} : w_sum[CNT_W-1:0];
  assign w_ovf_next   = (w_in_accum & r_ovf) | w_over;

  assign w_len_eff    = (win_len == '0) ? LEN_W'(1) : win_len;
  assign w_len_cur    = w_in_accum ? r_len : w_len_eff;
  assign w_beats_next = w_in_accum ? (r_beats + LEN_W'(1)) : LEN_W'(1);
  assign w_last       = (w_beats_next == w_len_cur);

  // While holding a result, input is accepted only if the result leaves in
  // the same cycle, which gives back-to-back windows with no bubble.
  assign in_ready  = !clear && ((r_state == ST_HOLD) ? out_ready : 1'b1);
  assign w_accept  = in_valid && in_ready;

  assign out_valid = (r_state == ST_HOLD);
  assign out_count = r_acc;
  assign out_ovf   = r_ovf;
  assign busy      = (r_state != ST_IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_acc   <= '0;
      r_beats <= '0;
      r_len   <= '0;
      r_ovf   <= 1'b0;
    end else if (clear) begin
      r_state <= ST_IDLE;
      r_acc   <= '0;
      r_beats <= '0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_acc   <= w_acc_next;
      r_beats <= w_beats_next;
      r_ovf   <= w_ovf_next;
      if (!w_in_accum) begin
        r_len <= w_len_eff;
      end
      r_state <= w_last ? ST_HOLD : ST_ACCUM;
    end else if ((r_state == ST_HOLD) && out_ready) begin
      r_state <= ST_IDLE;
    end
  end

endmodule
`default_nettype wire
